// File: rtl/pong_pkg.sv
// Shared definitions for the pong match logic.
// Holds the match state codes (also shown on the HUD through the estado
// output), the ganhador codes reported by the placar scoreboard, and the
// serve direction constants.
package pong_pkg;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    SAQUE  = 3'd1,
    JOGO   = 3'd2,
    PAUSA  = 3'd3,
    PONTO  = 3'd4,
    ESPERA = 3'd5,
    FIM    = 3'd6,
    LIMPA  = 3'd7
  } estado_t;

  localparam logic [1:0] GAN_NENHUM = 2'd0;
  localparam logic [1:0] GAN_ESQ    = 2'd1;
  localparam logic [1:0] GAN_DIR    = 2'd2;

  localparam logic DIR_ESQ = 1'b0;
  localparam logic DIR_DIR = 1'b1;

  // Code 3 from placar is not a win; only the two player codes end the match.
  function automatic logic tem_ganhador(input logic [1:0] ganhador);
    return (ganhador == GAN_ESQ) || (ganhador == GAN_DIR);
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Registered rising-edge detector for a debounced level input.
// Ports:
//   clock   - system clock
//   reset   - asynchronous active-low reset
//   entrada - level input (button)
//   borda   - one-cycle pulse, one clock after entrada is first seen high
// The history register clears on reset, so an input held through reset
// produces an edge as soon as reset is released.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic borda
);

  logic anterior;

  // History of the input plus the registered edge pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anterior <= 1'b0;
      borda    <= 1'b0;
    end else begin
      anterior <= entrada;
      borda    <= entrada & ~anterior;
    end
  end

endmodule

// File: rtl/controle_partida.sv
// Match sequencer for pong, between the ball/collision logic and placar.
// Ports:
//   clock, reset (async active-low)
//   frame_tick                      - one pulse per video frame
//   botao_inicio, botao_pausa       - debounced buttons, rising edge used
//   bola_saiu_esquerda/direita      - one-cycle ball exit pulses
//   ganhador                        - winner code read back from placar
//   ponto_esquerda/direita, enable  - one-cycle point strobe to placar
//   reset_placar                    - clears placar
//   bola_centro, bola_ativa         - ball centring / motion enable
//   saque_direcao                   - serve direction (0 left, 1 right)
//   estado                          - state code for debug/HUD
// Every output is a register loaded from the current state, so outputs
// follow a state change by one clock.
module controle_partida
  import pong_pkg::*;
#(
  parameter int FRAMES_SAQUE = 120,
  parameter int LAT_PLACAR   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       botao_inicio,
  input  logic       botao_pausa,
  input  logic       bola_saiu_esquerda,
  input  logic       bola_saiu_direita,
  input  logic [1:0] ganhador,
  output logic       ponto_esquerda,
  output logic       ponto_direita,
  output logic       enable,
  output logic       reset_placar,
  output logic       bola_centro,
  output logic       bola_ativa,
  output logic       saque_direcao,
  output logic [2:0] estado
);

  localparam int W_FRAME  = (FRAMES_SAQUE > 0) ? $clog2(FRAMES_SAQUE + 1) : 1;
  localparam int W_ESPERA = (LAT_PLACAR > 0) ? $clog2(LAT_PLACAR + 1) : 1;
  localparam logic [W_FRAME-1:0]  ULTIMO_FRAME =
    W_FRAME'((FRAMES_SAQUE > 0) ? FRAMES_SAQUE - 1 : 0);
  localparam logic [W_ESPERA-1:0] FIM_ESPERA = W_ESPERA'(LAT_PLACAR);

  estado_t               estado_q, estado_n;
  logic [W_FRAME-1:0]    cnt_frame_q, cnt_frame_n;
  logic [W_ESPERA-1:0]   cnt_espera_q, cnt_espera_n;
  logic                  lado_q, lado_n;
  logic                  borda_inicio, borda_pausa;
  logic                  en_n, pe_n, pd_n, rp_n, bc_n, ba_n, sd_n;

  detector_borda u_borda_inicio (
    .clock   (clock),
    .reset   (reset),
    .entrada (botao_inicio),
    .borda   (borda_inicio)
  );

  detector_borda u_borda_pausa (
    .clock   (clock),
    .reset   (reset),
    .entrada (botao_pausa),
    .borda   (borda_pausa)
  );

  // State, timers and the latched side of the last exit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= OCIOSO;
      cnt_frame_q  <= '0;
      cnt_espera_q <= '0;
      lado_q       <= DIR_ESQ;
    end else begin
      estado_q     <= estado_n;
      cnt_frame_q  <= cnt_frame_n;
      cnt_espera_q <= cnt_espera_n;
      lado_q       <= lado_n;
    end
  end

  // Next-state logic. Both timers default to zero, so they are already
  // clear whenever SAQUE or ESPERA is entered.
  always_comb begin
    estado_n     = estado_q;
    cnt_frame_n  = '0;
    cnt_espera_n = '0;
    lado_n       = lado_q;
    case (estado_q)
      OCIOSO: if (borda_inicio) estado_n = SAQUE;
      SAQUE: begin
        cnt_frame_n = cnt_frame_q;
        if (FRAMES_SAQUE == 0) begin
          estado_n = JOGO;
        end else if (frame_tick) begin
          if (cnt_frame_q == ULTIMO_FRAME) estado_n = JOGO;
          else cnt_frame_n = cnt_frame_q + W_FRAME'(1);
        end
      end
      JOGO: begin
        // Exits win over pause; a double exit is a void rally.
        if (bola_saiu_esquerda ^ bola_saiu_direita) begin
          estado_n = PONTO;
          lado_n   = bola_saiu_direita ? DIR_DIR : DIR_ESQ;
        end else if (bola_saiu_esquerda & bola_saiu_direita) begin
          estado_n = SAQUE;
        end else if (borda_pausa) begin
          estado_n = PAUSA;
        end
      end
      PAUSA: if (borda_pausa) estado_n = JOGO;
      PONTO: estado_n = ESPERA;
      ESPERA: begin
        // Give placar time to register the point before reading ganhador.
        if (cnt_espera_q == FIM_ESPERA)
          estado_n = tem_ganhador(ganhador) ? FIM : SAQUE;
        else
          cnt_espera_n = cnt_espera_q + W_ESPERA'(1);
      end
      FIM:   if (borda_inicio) estado_n = LIMPA;
      LIMPA: estado_n = SAQUE;
      default: estado_n = OCIOSO;
    endcase
  end

  // Output decode from the current state; registered below.
  always_comb begin
    en_n = 1'b0;
    pe_n = 1'b0;
    pd_n = 1'b0;
    rp_n = 1'b0;
    bc_n = 1'b0;
    ba_n = 1'b0;
    sd_n = saque_direcao;
    case (estado_q)
      OCIOSO: begin
        rp_n = 1'b1;
        bc_n = 1'b1;
        sd_n = DIR_ESQ;
      end
      SAQUE: bc_n = 1'b1;
      JOGO:  ba_n = 1'b1;
      PAUSA: begin
      end
      PONTO: begin
        en_n = 1'b1;
        pe_n = (lado_q == DIR_ESQ);
        pd_n = (lado_q == DIR_DIR);
        sd_n = lado_q;
      end
      ESPERA, FIM: bc_n = 1'b1;
      LIMPA: begin
        rp_n = 1'b1;
        bc_n = 1'b1;
        sd_n = DIR_ESQ;
      end
      default: begin
      end
    endcase
  end

  // Registered outputs; reset drops any pending strobe immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable         <= 1'b0;
      ponto_esquerda <= 1'b0;
      ponto_direita  <= 1'b0;
      reset_placar   <= 1'b1;
      bola_centro    <= 1'b1;
      bola_ativa     <= 1'b0;
      saque_direcao  <= DIR_ESQ;
      estado         <= OCIOSO;
    end else begin
      enable         <= en_n;
      ponto_esquerda <= pe_n;
      ponto_direita  <= pd_n;
      reset_placar   <= rp_n;
      bola_centro    <= bc_n;
      bola_ativa     <= ba_n;
      saque_direcao  <= sd_n;
      estado         <= estado_q;
    end
  end

endmodule

// File: doc/controle_partida.md
Name: controle_partida

Overview:
Match sequencer for the pong game; it sits between the ball/collision logic and the `placar` scoreboard.
- Converts ball-exit events into single-cycle point strobes for `placar`, reads back `ganhador`.
- Drives serve countdown, pause and game-over.
- Clears the scoreboard at match start and controls ball motion/centering.

Parameters:
- FRAMES_SAQUE, 120, frame_tick pulses spent in serve countdown before ball is released (2 s at 60 Hz).
- LAT_PLACAR, 2, clock cycles waited after a point strobe before `ganhador` is sampled.

Ports:
- clock  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- botao_inicio  in  1  start button (debounced, level); rising edge used.
- botao_pausa  in  1  pause button (debounced, level); rising edge used.
- bola_saiu_esquerda  in  1  one-cycle pulse: ball crossed left edge.
- bola_saiu_direita  in  1  one-cycle pulse: ball crossed right edge.
- ganhador  in  2  from placar: 0 running, 1 left player won, 2 right player won, 3 treated as 0.
- ponto_esquerda  out  1  one-cycle point strobe to placar (ball exited left).
- ponto_direita  out  1  one-cycle point strobe to placar (ball exited right).
- enable  out  1  placar write enable, high exactly in the strobe cycle.
- reset_placar  out  1  active-high clear to placar.
- bola_centro  out  1  hold ball at centre.
- bola_ativa  out  1  ball motion enable.
- saque_direcao  out  1  serve direction: 0 toward left, 1 toward right.
- estado  out  3  current state code, for debug/HUD.

Behaviour:
- Reset (reset=0, async): state OCIOSO.
  - Outputs: reset_placar=1, bola_centro=1; all other outputs 0; saque_direcao=0; timers cleared.
  - Edge-detector history registers load 0, so a button held through reset yields an edge on release of reset.
- Button edges: registered rising-edge detect on botao_inicio and botao_pausa; one cycle latency.
- States (estado code):
  - OCIOSO=0: reset_placar=1, bola_centro=1. Inicio edge -> SAQUE, saque_direcao=0.
  - SAQUE=1: bola_centro=1, bola_ativa=0, reset_placar=0.
    - Counts frame_tick; after FRAMES_SAQUE ticks -> JOGO.
    - FRAMES_SAQUE=0 -> JOGO next cycle.
  - JOGO=2: bola_ativa=1.
    - Exactly one of bola_saiu_* high -> PONTO, latching which side.
    - Both high in the same cycle -> no point; -> SAQUE, saque_direcao unchanged.
    - Pausa edge -> PAUSA; exit events in that same cycle take priority over pause.
  - PAUSA=3: bola_ativa=0, ball not centred.
    - Pausa edge -> JOGO.
    - Exit pulses ignored.
  - PONTO=4: single cycle.
    - enable=1 with ponto_esquerda or ponto_direita=1 per latched side.
    - saque_direcao <= side that conceded (left exit -> 0, right exit -> 1).
    - -> ESPERA.
  - ESPERA=5: bola_centro=1; waits LAT_PLACAR cycles, then samples ganhador.
    - ganhador 1 or 2 -> FIM.
    - Otherwise -> SAQUE.
  - FIM=6: bola_centro=1, bola_ativa=0. Inicio edge -> LIMPA.
  - LIMPA=7: reset_placar=1 for one cycle, saque_direcao=0 -> SAQUE.
- Event gating:
  - bola_saiu_* outside JOGO are ignored (never strobed).
  - Inicio edge outside OCIOSO/FIM is ignored.
  - Pausa edge outside JOGO/PAUSA is ignored.
- Strobe invariant: enable and ponto_* are never high outside PONTO, and never both ponto_* high together.
- Timers:
  - Frame counter width $clog2(FRAMES_SAQUE+1); cleared on every entry to SAQUE.
  - Wait counter width $clog2(LAT_PLACAR+1).
- Reset asserted mid-operation (including during PONTO or ESPERA) returns to OCIOSO immediately. Any pending strobe is dropped.
- All outputs registered (Moore), one cycle after state change.

Decomposition:
- Shared package `pong_pkg`:
  - state enum/localparams OCIOSO..LIMPA;
  - ganhador codes GAN_NENHUM=0, GAN_ESQ=1, GAN_DIR=2;
  - direction constants DIR_ESQ=0, DIR_DIR=1.
- Sub-module `detector_borda` (registered rising-edge detector with async active-low reset), instantiated for botao_inicio and botao_pausa.

Test Plan:
- Reset, then inicio edge -> reset_placar falls, estado=1. After 120 frame_ticks -> estado=2, bola_ativa=1. Tick 119 still estado=1.
- In JOGO, bola_saiu_esquerda pulse -> next cycle enable=1 and ponto_esquerda=1 for exactly 1 cycle; saque_direcao=0. ganhador=0 after LAT_PLACAR -> estado=1.
- In JOGO, both exit pulses in the same cycle -> no enable/ponto strobe; estado=1; saque_direcao unchanged.
- Pausa edge in JOGO -> estado=3, bola_ativa=0. Exit pulse ignored (no strobe). Second pausa edge -> estado=2.
- Point with ganhador=2 at sample time -> estado=6. Inicio edge -> estado=7 with reset_placar=1 for 1 cycle -> estado=1.
- reset driven low during ESPERA -> outputs at reset values asynchronously (before next clock edge); no strobe emitted after release.
